// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Opcode constants and immediate-format encoding shared by the
//                immediate decoder and the immediate/target pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_SH   = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } imm_fmt_e;

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode
//  Description : Combinational RISC-V immediate decoder. Produces the
//                XLEN-wide extended immediate, its format, whether the
//                target is pc-relative, and an illegal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            pc_rel_o,
    output logic            illegal_o
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign opc    = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    // Every format fits in a 32-bit signed value; the width step to XLEN is a
    // plain sign extension applied once below.
    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_NONE;
        pc_rel_o  = 1'b0;
        illegal_o = 1'b0;
        case (opc)
            OPC_LOAD, OPC_JALR: begin
                fmt_o = FMT_I;
                imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt_o = FMT_SH;
                    // On RV32 a 6th shamt bit names a shift beyond the word.
                    if (XLEN == 32 && inst_i[25]) begin
                        illegal_o = 1'b1;
                    end else begin
                        imm32 = 32'(inst_i[20 +: SHAMT_W]);
                    end
                end else begin
                    fmt_o = FMT_I;
                    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                end
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o    = FMT_B;
                pc_rel_o = 1'b1;
                imm32    = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                            inst_i[30:25], inst_i[11:8], 1'b0};
            end
            OPC_LUI: begin
                fmt_o = FMT_U;
                imm32 = {inst_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                fmt_o    = FMT_U;
                pc_rel_o = 1'b1;
                imm32    = {inst_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o    = FMT_J;
                pc_rel_o = 1'b1;
                imm32    = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                            inst_i[20], inst_i[30:21], 1'b0};
            end
            OPC_OP, OPC_SYSTEM, OPC_FENCE: begin
                fmt_o = FMT_NONE;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    // XLEN-31 copies of bit 31 plus bits 30:0 keeps the replication non-zero at XLEN=32.
    assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Two-stage valid/ready pipeline: stage 1 registers the decoded
//                immediate, stage 2 registers pc+imm (or pc+4) as the target.
//                Supports backpressure and a synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_pc_rel;
    logic            dec_illegal;

    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_imm_q;
    logic [XLEN-1:0] s1_pc_q;
    imm_fmt_e        s1_fmt_q;
    logic            s1_pc_rel_q;
    logic            s1_illegal_q;

    logic            s2_valid_q, s2_valid_d;
    logic [XLEN-1:0] s2_imm_q;
    logic [XLEN-1:0] s2_target_q;
    imm_fmt_e        s2_fmt_q;
    logic            s2_illegal_q;

    logic            s2_adv;
    logic            in_fire;
    logic [XLEN-1:0] target_d;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst_i    (inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .pc_rel_o  (dec_pc_rel),
        .illegal_o (dec_illegal)
    );

    assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;
    assign in_fire  = in_valid & in_ready;
    assign target_d = s1_pc_rel_q ? (s1_pc_q + s1_imm_q) : (s1_pc_q + PC_STEP);

    // Stage occupancy; flush wins over any same-cycle acceptance or advance.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s2_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // Valid flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage payloads load only on a transfer, so a stalled stage holds its data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_imm_q     <= '0;
            s1_pc_q      <= '0;
            s1_fmt_q     <= FMT_NONE;
            s1_pc_rel_q  <= 1'b0;
            s1_illegal_q <= 1'b0;
            s2_imm_q     <= '0;
            s2_target_q  <= '0;
            s2_fmt_q     <= FMT_NONE;
            s2_illegal_q <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_imm_q     <= dec_imm;
                s1_pc_q      <= pc;
                s1_fmt_q     <= dec_fmt;
                s1_pc_rel_q  <= dec_pc_rel;
                s1_illegal_q <= dec_illegal;
            end
            if (s2_adv) begin
                s2_imm_q     <= s1_imm_q;
                s2_target_q  <= target_d;
                s2_fmt_q     <= s1_fmt_q;
                s2_illegal_q <= s1_illegal_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign imm       = s2_imm_q;
    assign target    = s2_target_q;
    assign fmt       = s2_fmt_q;
    assign illegal   = s2_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe at XLEN=32 and XLEN=64,
//                both instances driven by the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_SH = 3'd2, F_S = 3'd3,
                           F_B = 3'd4, F_U = 3'd5, F_J = 3'd6;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] inst;
    logic [63:0] pc;

    logic        ir32, ov32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic        ir64, ov64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last_o [2];
    bit   hold_f [2];
    int   emit_cnt [2];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(ir32), .inst(inst), .pc(pc[31:0]), .out_valid(ov32),
        .out_ready(out_ready), .imm(imm32), .target(tgt32), .fmt(fmt32),
        .illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(ir64), .inst(inst), .pc(pc), .out_valid(ov64),
        .out_ready(out_ready), .imm(imm64), .target(tgt64), .fmt(fmt64),
        .illegal(ill64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    function automatic longint sx(input longint v, input int bits);
        return (v <<< (64 - bits)) >>> (64 - bits);
    endfunction

    // Architectural reference: immediate value, format and target by opcode.
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] p, input int xlen);
        exp_t        e;
        longint      v;
        logic [63:0] mask;
        bit          rel;
        mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
        v     = 0;
        rel   = 0;
        e.fmt = F_NONE;
        e.ill = 1'b0;
        case (i[6:0])
            7'h03, 7'h67: begin e.fmt = F_I; v = sx({52'd0, i[31:20]}, 12); end
            7'h13: begin
                if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
                    e.fmt = F_SH;
                    if (int'(i[25:20]) >= xlen) e.ill = 1'b1;
                    else v = longint'(i[25:20]);
                end else begin
                    e.fmt = F_I; v = sx({52'd0, i[31:20]}, 12);
                end
            end
            7'h23: begin e.fmt = F_S; v = sx({52'd0, i[31:25], i[11:7]}, 12); end
            7'h63: begin
                e.fmt = F_B; rel = 1;
                v = sx({51'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            end
            7'h37: begin e.fmt = F_U; v = sx({32'd0, i[31:12], 12'd0}, 32); end
            7'h17: begin e.fmt = F_U; rel = 1; v = sx({32'd0, i[31:12], 12'd0}, 32); end
            7'h6F: begin
                e.fmt = F_J; rel = 1;
                v = sx({43'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            end
            7'h33, 7'h73, 7'h0F: ;
            default: e.ill = 1'b1;
        endcase
        e.imm = 64'(v) & mask;
        e.tgt = rel ? ((p + 64'(v)) & mask) : ((p + 64'd4) & mask);
        return e;
    endfunction

    // Per-instance scoreboard step for one sampling point.
    task automatic scb(input int d, input logic ov, input logic ir, input exp_t cur);
        exp_t e;
        int   occ;
        occ = (d == 0) ? q0.size() : q1.size();
        chk(d == 0 ? "in_ready32" : "in_ready64", 64'(ir), 64'((occ < 2) || out_ready));
        if (hold_f[d] && ov) begin
            chk(d == 0 ? "hold32" : "hold64", 64'(cur.imm ^ last_o[d].imm ^ cur.tgt ^ last_o[d].tgt)
                | 64'(cur.fmt ^ last_o[d].fmt) | 64'(cur.ill ^ last_o[d].ill), 64'd0);
        end
        if (ov) begin
            if (occ == 0) begin
                chk(d == 0 ? "spurious32" : "spurious64", 64'(ov), 64'd0);
            end else if (out_ready) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk(d == 0 ? "imm32" : "imm64", cur.imm, e.imm);
                chk(d == 0 ? "tgt32" : "tgt64", cur.tgt, e.tgt);
                chk(d == 0 ? "fmt32" : "fmt64", 64'(cur.fmt), 64'(e.fmt));
                chk(d == 0 ? "ill32" : "ill64", 64'(cur.ill), 64'(e.ill));
                emit_cnt[d]++;
            end
        end
        hold_f[d] = ov && !out_ready && !flush;
        last_o[d] = cur;
    endtask

    // Compare process: sampled mid-cycle, ahead of the edge that acts on it.
    always @(negedge clk) begin
        if (reset) begin
            hold_f[0] = 0;
            hold_f[1] = 0;
        end else begin
            scb(0, ov32, ir32, '{{32'd0, imm32}, {32'd0, tgt32}, fmt32, ill32});
            scb(1, ov64, ir64, '{imm64, tgt64, fmt64, ill64});
            if (flush) begin
                q0.delete();
                q1.delete();
            end else if (in_valid && ir32) begin
                q0.push_back(model(inst, pc, 32));
                q1.push_back(model(inst, pc, 64));
            end
        end
    end

    // Offer one instruction and hold it until accepted.
    task automatic push(input logic [31:0] i, input logic [63:0] p, input bit rnd);
        int n;
        n        = 0;
        inst     = i;
        pc       = p;
        in_valid = 1'b1;
        forever begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (ir32) break;
            @(posedge clk);
            #1;
            n++;
            if (n > 40) begin bound_fail("push"); break; end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Single instruction on an idle pipeline with literal expectations.
    task automatic lit(input string nm, input int d, input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] eimm, input logic [63:0] etgt,
                       input logic [2:0] ef, input logic eil);
        out_ready = 1'b1;
        inst      = i;
        pc        = p;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk({nm, "_lat"}, 64'(d == 0 ? ov32 : ov64), 64'd0);
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, 64'(d == 0 ? ov32 : ov64), 64'd1);
        chk({nm, "_imm"}, d == 0 ? {32'd0, imm32} : imm64, eimm);
        chk({nm, "_tgt"}, d == 0 ? {32'd0, tgt32} : tgt64, etgt);
        chk({nm, "_fmt"}, 64'(d == 0 ? fmt32 : fmt64), 64'(ef));
        chk({nm, "_ill"}, 64'(d == 0 ? ill32 : ill64), 64'(eil));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) bound_fail("drain");
        @(posedge clk);
        #1;
    endtask

    localparam int NTAB = 10;
    logic [31:0] tab [NTAB] = '{32'hFFF00093, 32'hFE000CE3, 32'h123452B7, 32'h001000EF,
                                32'hFFF04083, 32'hFE112E23, 32'h02809093, 32'h0000007F,
                                32'h00000033, 32'h00004501};

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0;
        logic [31:0] snap;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inst      = '0;
        pc        = '0;
        #12;
        chk("rst_valid", 64'(ov32), 64'd0);
        chk("rst_imm", {32'd0, imm32}, 64'd0);
        chk("rst_tgt", {32'd0, tgt32}, 64'd0);
        chk("rst_fmt", 64'(fmt32), 64'(F_NONE));
        chk("rst_ill", 64'(ill32), 64'd0);
        chk("rst_valid64", 64'(ov64), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(ir32), 64'd1);

        // Directed vectors with hand-computed results.
        lit("addi",    0, 32'hFFF00093, 64'h0,    64'hFFFFFFFF, 64'h4,        F_I,    1'b0);
        lit("beq",     0, 32'hFE000CE3, 64'h100,  64'hFFFFFFF8, 64'hF8,       F_B,    1'b0);
        lit("beqwrap", 0, 32'hFE000CE3, 64'h0,    64'hFFFFFFF8, 64'hFFFFFFF8, F_B,    1'b0);
        lit("lui",     0, 32'h123452B7, 64'h40,   64'h12345000, 64'h44,       F_U,    1'b0);
        lit("jal",     0, 32'h001000EF, 64'h1000, 64'h800,      64'h1800,     F_J,    1'b0);
        lit("lbu",     0, 32'hFFF04083, 64'h0,    64'hFFFFFFFF, 64'h4,        F_I,    1'b0);
        lit("sw",      0, 32'hFE112E23, 64'h20,   64'hFFFFFFFC, 64'h24,       F_S,    1'b0);
        lit("add",     0, 32'h00000033, 64'h8,    64'h0,        64'hC,        F_NONE, 1'b0);
        lit("rvc",     0, 32'h00004501, 64'h8,    64'h0,        64'hC,        F_NONE, 1'b1);
        lit("slli32",  0, 32'h02809093, 64'h200,  64'h0,        64'h204,      F_SH,   1'b1);
        lit("addi64",  1, 32'hFFF00093, 64'h0,    64'hFFFFFFFFFFFFFFFF, 64'h4, F_I,   1'b0);
        lit("slli64",  1, 32'h02809093, 64'h200,  64'd40,       64'h204,      F_SH,   1'b0);
        lit("beq64",   1, 32'hFE000CE3, 64'h0,    64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, F_B, 1'b0);
        lit("opc7f64", 1, 32'h0000007F, 64'h0,    64'h0,        64'h4,        F_NONE, 1'b1);

        // Streaming with random backpressure; scoreboard checks order and values.
        for (int k = 0; k < 30; k++) begin
            push(tab[k % NTAB], {$urandom, $urandom}, 1'b1);
        end
        drain();

        // Backpressure: two entries fill the pipe, the third waits.
        out_ready = 1'b0;
        e0        = emit_cnt[0];
        inst      = 32'hFFF00093;
        pc        = 64'h0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready1", 64'(ir32), 64'd1);
        inst = 32'h001000EF;
        pc   = 64'h1000;
        @(posedge clk);
        #1;
        chk("bp_full", 64'(ir32), 64'd0);
        inst = 32'h123452B7;
        pc   = 64'h2000;
        snap = imm32;
        chk("bp_head_imm", {32'd0, imm32}, 64'hFFFFFFFF);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("bp_stall_ready", 64'(ir32), 64'd0);
            chk("bp_stall_imm", {32'd0, imm32}, {32'd0, snap});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_count", 64'(emit_cnt[0] - e0), 64'd3);

        // Flush with two stalled entries and a same-cycle offer.
        out_ready = 1'b0;
        inst      = 32'hFE000CE3;
        pc        = 64'h300;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("fl_full", 64'(ir32), 64'd0);
        flush = 1'b1;
        inst  = 32'h123452B7;
        e0    = emit_cnt[0];
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(ov32), 64'd0);
        chk("fl_valid64", 64'(ov64), 64'd0);
        chk("fl_ready", 64'(ir32), 64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("fl_none", 64'(emit_cnt[0] - e0), 64'd0);

        // Reset mid-stream with an illegal entry at the head.
        out_ready = 1'b0;
        inst      = 32'h0000007F;
        pc        = 64'h400;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 inst = 32'hFE000CE3;
        @(posedge clk);
        #2;
        chk("mr_pre_ill", 64'(ill32), 64'd1);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        hold_f[0] = 0;
        hold_f[1] = 0;
        #1;
        chk("mr_valid", 64'(ov32), 64'd0);
        chk("mr_imm", {32'd0, imm32}, 64'd0);
        chk("mr_tgt", {32'd0, tgt32}, 64'd0);
        chk("mr_fmt", 64'(fmt32), 64'(F_NONE));
        chk("mr_ill", 64'(ill32), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_ready", 64'(ir32), 64'd1);
        chk("mr_valid_after", 64'(ov32), 64'd0);

        // A short stream after reset still flows correctly.
        for (int k = 0; k < 6; k++) begin
            push(tab[(k * 3) % NTAB], 64'h8000_0000 + 64'(k * 4), 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
